// File: rtl/psum_acc_if.sv
// Handshake bundle between the adder tree, psum_acc and the result consumer.
interface psum_acc_if #(
  parameter int DWIDTH = 25,
  parameter int OWIDTH = 8
);
  logic              psum_vld;
  logic [DWIDTH-1:0] psum_data;
  logic              out_vld;
  logic [OWIDTH-1:0] out_data;
  logic              out_rdy;

  modport master (output psum_vld, psum_data, out_rdy, input out_vld, out_data);
  modport slave  (input psum_vld, psum_data, out_rdy, output out_vld, out_data);
endinterface

// File: rtl/psum_acc.sv
// Row-buffer accumulator for conv partial sums: accumulates npass passes per column,
// then rounds, shifts, ReLUs and saturates each column into a small output FIFO.
module psum_acc #(
  parameter int DWIDTH      = 25,
  parameter int ACC_WIDTH   = 32,
  parameter int OWIDTH      = 8,
  parameter int ROW_LEN     = 32,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(ROW_LEN+1)-1:0] cfg_row_len,
  input  logic [7:0]                   cfg_npass,
  input  logic [4:0]                   cfg_shift,
  input  logic                         cfg_relu,
  psum_acc_if.slave                    io,
  output logic                         busy,
  output logic                         done,
  output logic                         err_ovf
);
  localparam int CW = $clog2(ROW_LEN+1);
  localparam int IW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'((1 << (OWIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] OMIN = -OMAX - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;

  logic [CW-1:0] row_len;
  logic [7:0]    npass, pass;
  logic [4:0]    shift;
  logic          relu;
  logic [IW-1:0] col;

  logic signed [ACC_WIDTH-1:0] rbuf [ROW_LEN];
  logic signed [ACC_WIDTH-1:0] x, acc_new;
  logic beat, last_col, last_pass;

  assign beat      = (state == RUN) && io.psum_vld;
  assign last_col  = (col == IW'(row_len - CW'(1)));
  assign last_pass = (pass == npass - 8'd1);
  assign x         = ACC_WIDTH'($signed(io.psum_data));
  // Pass 0 overwrites, so the buffer never needs clearing between rows.
  assign acc_new   = (pass == 8'd0) ? x : rbuf[col] + x;

  always_ff @(posedge clk)
    if (beat) rbuf[col] <= acc_new;

  // Round-half-up, arithmetic shift, ReLU, saturate; one extra bit keeps the rounding add exact.
  logic signed [ACC_WIDTH:0] rnd, rsum, rsh, rclip;
  always_comb begin
    rnd   = (shift == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
    rsum  = {acc_new[ACC_WIDTH-1], acc_new} + rnd;
    rsh   = rsum >>> shift;
    rclip = rsh;
    if (relu && rsh < 0)  rclip = '0;
    else if (rsh > OMAX)  rclip = OMAX;
    else if (rsh < OMIN)  rclip = OMIN;
  end

  logic              q_vld;
  logic [OWIDTH-1:0] q_data;

  logic [OWIDTH-1:0] fmem [OFIFO_DEPTH];
  logic [PW:0]       wptr, rptr;
  logic empty, full, push, pop, ovf;

  assign empty       = (wptr == rptr);
  assign full        = ((wptr - rptr) == (PW+1)'(OFIFO_DEPTH));
  assign pop         = io.out_vld && io.out_rdy;
  // A pop in the same cycle frees the slot, so full alone does not drop.
  assign push        = q_vld && (!full || pop);
  assign ovf         = q_vld && full && !pop;
  assign io.out_vld  = !empty;
  assign io.out_data = empty ? '0 : fmem[rptr[PW-1:0]];

  always_ff @(posedge clk)
    if (push) fmem[wptr[PW-1:0]] <= q_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_len <= CW'(1);
      npass   <= 8'd1;
      shift   <= '0;
      relu    <= 1'b0;
      col     <= '0;
      pass    <= '0;
      q_vld   <= 1'b0;
      q_data  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      done   <= 1'b0;
      q_vld  <= beat && last_pass;
      q_data <= OWIDTH'(rclip);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (ovf)  err_ovf <= 1'b1;
      case (state)
        IDLE: if (start) begin
          row_len <= (cfg_row_len == '0) ? CW'(1) :
                     (cfg_row_len > CW'(ROW_LEN)) ? CW'(ROW_LEN) : cfg_row_len;
          npass   <= (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
          shift   <= cfg_shift;
          relu    <= cfg_relu;
          col     <= '0;
          pass    <= '0;
          err_ovf <= 1'b0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: if (beat) begin
          if (last_col) begin
            col <= '0;
            if (last_pass) state <= FLUSH;
            else           pass  <= pass + 8'd1;
          end else begin
            col <= col + 1'b1;
          end
        end
        FLUSH: if (!q_vld && empty) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_acc.sv
// Self-checking bench for psum_acc: directed plan scenarios plus randomized jobs vs a row-sum model.
module tb_psum_acc;
  localparam int DW = 25, AW = 32, OW = 8, RL = 32, FD = 4;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] cfg_row_len = '0;
  logic [7:0] cfg_npass = '0;
  logic [4:0] cfg_shift = '0;
  logic       cfg_relu = 1'b0;
  logic       busy, done, err_ovf;

  psum_acc_if #(.DWIDTH(DW), .OWIDTH(OW)) ifc();

  psum_acc #(.DWIDTH(DW), .ACC_WIDTH(AW), .OWIDTH(OW), .ROW_LEN(RL), .OFIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_row_len(cfg_row_len), .cfg_npass(cfg_npass),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .io(ifc), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, done_cnt = 0;
  int got[$], exp_q[$], stim[$];

  // Outputs are sampled on the falling edge; handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && ifc.out_vld && ifc.out_rdy) got.push_back(int'($signed(ifc.out_data)));
    if (done) done_cnt++;
  end

  function automatic int quant(longint s, int sh, bit rel);
    longint r = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
    longint hi = (longint'(1) << (OW - 1)) - 1;
    r = r >>> sh;
    if (rel && r < 0) r = 0;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return int'(r);
  endfunction

  // Column result = wrapped sum over all passes of that column's beats.
  function automatic void model(int rl, int np, int sh, bit rel);
    int rle = (rl == 0) ? 1 : (rl > RL ? RL : rl);
    int npe = (np == 0) ? 1 : np;
    exp_q.delete();
    for (int c = 0; c < rle; c++) begin
      longint s = 0;
      for (int p = 0; p < npe; p++) s += longint'(stim[p*rle + c]);
      exp_q.push_back(quant(longint'(int'(s)), sh, rel));
    end
  endfunction

  task automatic drive_job(input int rl, input int np, input int sh, input bit rel, input bit gaps);
    cfg_row_len = 6'(rl); cfg_npass = 8'(np); cfg_shift = 5'(sh); cfg_relu = rel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (stim[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      ifc.psum_vld = 1'b1; ifc.psum_data = stim[i][DW-1:0];
      @(posedge clk); #1;
      ifc.psum_vld = 1'b0;
    end
  endtask

  task automatic wait_done(output bit tmo);
    tmo = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin tmo = 1'b0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (ifc.out_vld !== 1'b0) begin miscompares++; $display("FAIL reset out_vld: got %b want 0", ifc.out_vld); end
    vectors++; if (ifc.out_data !== '0) begin miscompares++; $display("FAIL reset out_data: got %0d want 0", ifc.out_data); end
    vectors++; if ({busy, done, err_ovf} !== 3'b000) begin miscompares++; $display("FAIL reset busy/done/err: got %b want 000", {busy, done, err_ovf}); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int d0 = done_cnt; bit tmo;
    got.delete();
    cfg_row_len = 6'd4; cfg_npass = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sat busy rise: got %b want 1", busy); end
    ifc.psum_vld = 1'b1; ifc.psum_data = DW'(1);
    @(posedge clk); #1; ifc.psum_data = DW'(-2);
    @(negedge clk);
    vectors++; if (ifc.out_vld !== 1'b0) begin miscompares++; $display("FAIL sat latency t+1: got %b want 0", ifc.out_vld); end
    @(posedge clk); #1; ifc.psum_data = DW'(127);
    @(negedge clk);
    vectors++; if (ifc.out_vld !== 1'b1) begin miscompares++; $display("FAIL sat latency t+2: got %b want 1", ifc.out_vld); end
    @(posedge clk); #1; ifc.psum_data = DW'(200);
    @(posedge clk); #1; ifc.psum_vld = 1'b0;
    wait_done(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL sat done: got timeout want pulse"); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sat busy fall: got %b want 0", busy); end
    repeat (3) @(posedge clk); #1;
    vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL sat done count: got %0d want %0d", done_cnt - d0, 1); end
    exp_q = '{1, -2, 127, 127};
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL sat count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL sat out[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
    end
  endtask

  task automatic test_multipass;
    bit tmo;
    for (int rel = 0; rel < 2; rel++) begin
      got.delete();
      stim = '{10, -5, 20, -5, 30, -5};
      drive_job(2, 3, 2, rel[0], 1'b0);
      wait_done(tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL multipass done relu=%0d: got timeout want pulse", rel); end
      exp_q = (rel == 0) ? '{15, -4} : '{15, 0};
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL multipass count relu=%0d: got %0d want %0d", rel, got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL multipass relu=%0d out[%0d]: got %0d want %0d", rel, i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
    end
  endtask

  task automatic test_rounding;
    bit tmo;
    got.delete();
    stim = '{3, -3, -4};
    drive_job(3, 1, 1, 1'b0, 1'b0);
    wait_done(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL round done: got timeout want pulse"); end
    exp_q = '{2, -1, -2};
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL round count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL round out[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
    end
  endtask

  task automatic test_overflow;
    bit tmo;
    got.delete();
    ifc.out_rdy = 1'b0;
    stim = '{1, 2, 3, 4, 5, 6};
    drive_job(6, 1, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf flag: got %b want 1", err_ovf); end
    vectors++; if (ifc.out_vld !== 1'b1 || ifc.out_data !== 8'd1) begin miscompares++; $display("FAIL ovf head: got vld=%b data=%0d want vld=1 data=1", ifc.out_vld, ifc.out_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf busy while stalled: got %b want 1", busy); end
    ifc.out_rdy = 1'b1;
    wait_done(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL ovf done: got timeout want pulse"); end
    exp_q = '{1, 2, 3, 4};
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovf out[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
    end
    repeat (3) @(posedge clk); #1;
    vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf sticky: got %b want 1", err_ovf); end
  endtask

  task automatic test_reset_midjob;
    int d0; bit tmo;
    cfg_row_len = 6'd4; cfg_npass = 8'd2; cfg_shift = 5'd0; cfg_relu = 1'b0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL start clears err_ovf: got %b want 0", err_ovf); end
    for (int i = 0; i < 6; i++) begin
      ifc.psum_vld = 1'b1; ifc.psum_data = DW'(i + 1);
      @(posedge clk); #1;
    end
    ifc.psum_vld = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    d0 = done_cnt;
    got.delete();
    @(negedge clk);
    vectors++; if (ifc.out_vld !== 1'b0) begin miscompares++; $display("FAIL midreset out_vld: got %b want 0", ifc.out_vld); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset busy: got %b want 0", busy); end
    repeat (10) @(posedge clk); #1;
    vectors++; if (done_cnt !== d0 || got.size() != 0) begin miscompares++; $display("FAIL midreset quiet: got done=%0d outs=%0d want 0 0", done_cnt - d0, got.size()); end
    stim = '{1, 1, 1, 1, 1, 1, 1, 1};
    drive_job(4, 2, 0, 1'b0, 1'b0);
    wait_done(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL clean job done: got timeout want pulse"); end
    exp_q = '{2, 2, 2, 2};
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL clean job count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL clean job out[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
    end
  endtask

  task automatic test_ignored;
    int d0; bit tmo;
    got.delete();
    for (int i = 0; i < 5; i++) begin
      ifc.psum_vld = 1'b1; ifc.psum_data = DW'($urandom);
      @(posedge clk); #1;
    end
    ifc.psum_vld = 1'b0;
    repeat (5) @(posedge clk); #1;
    vectors++; if (got.size() != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle psum: got outs=%0d busy=%b want 0 0", got.size(), busy); end
    d0 = done_cnt;
    cfg_row_len = 6'd3; cfg_npass = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    ifc.psum_vld = 1'b1; ifc.psum_data = DW'(5);
    @(posedge clk); #1;
    start = 1'b1; cfg_row_len = 6'd1; cfg_npass = 8'd2; ifc.psum_data = DW'(6);
    @(posedge clk); #1;
    start = 1'b0; ifc.psum_data = DW'(7);
    @(posedge clk); #1;
    ifc.psum_vld = 1'b0;
    wait_done(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL restart done: got timeout want pulse"); end
    repeat (3) @(posedge clk); #1;
    vectors++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin miscompares++; $display("FAIL restart done count/busy: got %0d/%b want 1/0", done_cnt - d0, busy); end
    exp_q = '{5, 6, 7};
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL restart count: got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL restart out[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
    end
  endtask

  task automatic test_random;
    bit tmo;
    for (int j = 0; j < 12; j++) begin
      int rl = (j == 0) ? 0 : (j == 1) ? 40 : int'($urandom_range(1, 8));
      int np = (j == 0) ? 0 : (j == 1) ? 1 : int'($urandom_range(1, 4));
      int sh = int'($urandom_range(0, 20));
      bit rel = 1'($urandom);
      int rle = (rl == 0) ? 1 : (rl > RL ? RL : rl);
      int npe = (np == 0) ? 1 : np;
      got.delete(); stim.delete();
      for (int i = 0; i < rle * npe; i++) begin
        int v = int'($urandom) >>> 7;
        if ($urandom_range(0, 1) == 0) v = v >>> 14;
        stim.push_back(v);
      end
      model(rl, np, sh, rel);
      drive_job(rl, np, sh, rel, 1'b1);
      wait_done(tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL rand job %0d done: got timeout want pulse", j); end
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL rand job %0d count: got %0d want %0d", j, got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        vectors++; if (i >= got.size() || got[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand job %0d out[%0d]: got %0d want %0d", j, i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
    end
  endtask

  initial begin
    ifc.psum_vld = 1'b0; ifc.psum_data = '0; ifc.out_rdy = 1'b1;
    test_reset();
    test_saturation();
    test_multipass();
    test_rounding();
    test_overflow();
    test_reset_midjob();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
